// File: rtl/pcm_pkg.sv
// Shared types and constants for the PCM frame packer.
// Optional checksum word is enabled with PCM_FRAME_CHECKSUM_EN.
package pcm_pkg;

    localparam int PCM_W  = 16;
    localparam int DROP_W = 8;
    localparam logic [PCM_W-1:0] PCM_HDR = 16'hA55A;

    typedef logic [PCM_W-1:0] pcm_word_t;

    typedef enum logic [2:0] {IDLE, HDR, CNT, DATA, CSUM} pcm_state_e;

endpackage

// File: rtl/pcm_frame_packer_snapshot_buf.sv
// NCH x W capture register; loaded only on a frame capture, read by channel index.
module pcm_snapshot_buf #(
    parameter int NCH = 20,
    parameter int W   = 16,
    parameter int CW  = 5
) (
    input  logic           CLKDIVH2,
    input  logic           RST,
    input  logic           load,
    input  logic [NCH*W-1:0] din,
    input  logic [CW-1:0]  sel,
    output logic [W-1:0]   dout
);

    logic [NCH*W-1:0] snap_q, snap_d;

    always_comb begin
        snap_d = load ? din : snap_q;
    end

    always_ff @(posedge CLKDIVH2 or posedge RST) begin
        if (RST) snap_q <= '0;
        else     snap_q <= snap_d;
    end

    // Out-of-range indices read as zero.
    always_comb begin
        dout = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel == CW'(i)) dout = snap_q[i*W +: W];
        end
    end

endmodule

// File: rtl/pcm_frame_packer.sv
// Snapshots all PCM channels and streams HDR, frame count, channel words over valid/ready.
// Build with PCM_FRAME_CHECKSUM_EN to append an XOR checksum word to every frame.
module pcm_frame_packer
    import pcm_pkg::*;
#(
    parameter int NCH = 20,
    parameter int W   = PCM_W,
    parameter logic [W-1:0] HDR_WORD = W'(PCM_HDR)
) (
    input  logic               CLKDIVH2,
    input  logic               RST,
    input  logic [NCH*W-1:0]   pcm_in,
    input  logic               pcm_valid,
    output logic [W-1:0]       out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic               busy,
    output logic [DROP_W-1:0]  drop_cnt
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] CH_LAST = CW'(NCH - 1);
`ifdef PCM_FRAME_CHECKSUM_EN
    localparam bit LAST_ON_DATA = 1'b0;
`else
    localparam bit LAST_ON_DATA = 1'b1;
`endif

    pcm_state_e        state_q, state_d;
    logic [CW-1:0]     ch_q, ch_d, ch_nxt;
    logic [W-1:0]      out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              out_last_q, out_last_d;
    pcm_word_t         frame_cnt_q, frame_cnt_d;
    logic [DROP_W-1:0] drop_q, drop_d;
`ifdef PCM_FRAME_CHECKSUM_EN
    logic [W-1:0]      csum_q, csum_d;
`endif

    logic              xfer, frame_end, capture, snap_load;
    logic [CW-1:0]     snap_sel;
    logic [W-1:0]      snap_rd;

    assign ch_nxt   = ch_q + 1'b1;
    // Read address is the word being loaded into out_data on this transfer.
    assign snap_sel = (state_q == CNT) ? '0 : ch_nxt;

    pcm_snapshot_buf #(.NCH(NCH), .W(W), .CW(CW)) u_snap (
        .CLKDIVH2 (CLKDIVH2),
        .RST      (RST),
        .load     (snap_load),
        .din      (pcm_in),
        .sel      (snap_sel),
        .dout     (snap_rd)
    );

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_cnt_d = frame_cnt_q;
        drop_d      = drop_q;
`ifdef PCM_FRAME_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        xfer        = out_valid_q & out_ready;
        frame_end   = 1'b0;
        capture     = 1'b0;
        snap_load   = 1'b0;

        case (state_q)
            IDLE: capture = pcm_valid;
            HDR: if (xfer) begin
                state_d    = CNT;
                out_data_d = W'(frame_cnt_q);
`ifdef PCM_FRAME_CHECKSUM_EN
                csum_d     = W'(frame_cnt_q);
`endif
            end
            CNT: if (xfer) begin
                state_d    = DATA;
                ch_d       = '0;
                out_data_d = snap_rd;
                out_last_d = LAST_ON_DATA && (NCH == 1);
`ifdef PCM_FRAME_CHECKSUM_EN
                csum_d     = csum_q ^ snap_rd;
`endif
            end
            DATA: if (xfer) begin
                if (ch_q == CH_LAST) begin
`ifdef PCM_FRAME_CHECKSUM_EN
                    state_d    = CSUM;
                    out_data_d = csum_q;
                    out_last_d = 1'b1;
`else
                    frame_end  = 1'b1;
`endif
                end else begin
                    ch_d       = ch_nxt;
                    out_data_d = snap_rd;
                    out_last_d = LAST_ON_DATA && (ch_nxt == CH_LAST);
`ifdef PCM_FRAME_CHECKSUM_EN
                    csum_d     = csum_q ^ snap_rd;
`endif
                end
            end
`ifdef PCM_FRAME_CHECKSUM_EN
            CSUM: frame_end = xfer;
`endif
            default: state_d = IDLE;
        endcase

        // A capture on the final-word transfer starts the next frame with no bubble.
        if (frame_end) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
            capture     = pcm_valid;
            if (!pcm_valid) begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        end

        if (capture) begin
            snap_load   = 1'b1;
            state_d     = HDR;
            out_valid_d = 1'b1;
            out_data_d  = HDR_WORD;
            out_last_d  = 1'b0;
        end

        if (pcm_valid && (state_q != IDLE) && !frame_end && (drop_q != '1))
            drop_d = drop_q + 1'b1;
    end

    always_ff @(posedge CLKDIVH2 or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            ch_q        <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_cnt_q <= '0;
            drop_q      <= '0;
`ifdef PCM_FRAME_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_cnt_q <= frame_cnt_d;
            drop_q      <= drop_d;
`ifdef PCM_FRAME_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = (state_q != IDLE);
    assign drop_cnt  = drop_q;

endmodule
